// File: rtl/mc_dp_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset datapath:
// FSM states, instruction classes, op/cmd/cond codes, NZCV bit indices.
package mc_dp_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_DP, K_MUL, K_LDR, K_STR, K_BR
  } kind_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'h0;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_ADD = 4'h4;
  localparam logic [3:0] CMD_CMP = 4'hA;
  localparam logic [3:0] CMD_ORR = 4'hC;

  localparam logic [3:0] C_EQ = 4'h0;
  localparam logic [3:0] C_NE = 4'h1;
  localparam logic [3:0] C_CS = 4'h2;
  localparam logic [3:0] C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4;
  localparam logic [3:0] C_PL = 4'h5;
  localparam logic [3:0] C_GE = 4'hA;
  localparam logic [3:0] C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC;
  localparam logic [3:0] C_LE = 4'hD;
  localparam logic [3:0] C_AL = 4'hE;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Condition codes outside the supported set evaluate false,
  // so such instructions are skipped without side effects.
  function automatic logic cond_ok(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    n  = f[F_N];
    z  = f[F_Z];
    cy = f[F_C];
    v  = f[F_V];
    case (c)
      C_EQ:    cond_ok = z;
      C_NE:    cond_ok = !z;
      C_CS:    cond_ok = cy;
      C_CC:    cond_ok = !cy;
      C_MI:    cond_ok = n;
      C_PL:    cond_ok = !n;
      C_GE:    cond_ok = (n == v);
      C_LT:    cond_ok = (n != v);
      C_GT:    cond_ok = !z && (n == v);
      C_LE:    cond_ok = z || (n != v);
      C_AL:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREG x DATA_W, two async reads, one sync write.
// Index NREG-1 reads as i_pc8 and is never written.
module mc_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_ra,
  input  logic [3:0]        i_rb,
  output logic [DATA_W-1:0] o_rda,
  output logic [DATA_W-1:0] o_rdb,
  input  logic              i_we,
  input  logic [3:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [DATA_W-1:0] i_pc8
);

  logic [DATA_W-1:0] r_regs [NREG-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG-1; i++)
        r_regs[i] <= '0;
    end else if (i_we && int'(i_wa) < NREG-1) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rda = '0;
    if (int'(i_ra) == NREG-1)
      o_rda = i_pc8;
    else if (int'(i_ra) < NREG-1)
      o_rda = r_regs[i_ra];
  end

  always_comb begin
    o_rdb = '0;
    if (int'(i_rb) == NREG-1)
      o_rdb = i_pc8;
    else if (int'(i_rb) < NREG-1)
      o_rdb = r_regs[i_rb];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle ARM-subset datapath: FSM, regfile, ALU, NZCV, imem/dmem
// req/ready. Ports: clk/reset, imem_*, dmem_*, pc, alu_flags, retire,
// halted. Option MC_DP_MUL_EN enables MUL (else that encoding is a NOP).
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        alu_flags,
  output logic              retire,
  output logic              halted
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_a, r_b, r_ldata;
  logic [3:0]        r_flags;

  kind_t             w_kind;
  logic              w_retire;
  logic [1:0]        w_op;
  logic [3:0]        w_cmd;
  logic              w_imm, w_s;
  logic              w_is_dp, w_is_mul, w_is_mem, w_is_br;
  logic [3:0]        w_ra, w_rb, w_wa;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_opb, w_wd, w_res;
  logic [DATA_W-1:0] w_pc8;
  logic [DATA_W:0]   w_sum, w_dif;
  logic              w_c, w_v;
  logic [3:0]        w_nzcv;
  logic              w_rf_we, w_flag_we;
  logic signed [31:0] w_boff;
  logic [ADDR_W-1:0] w_btgt;

  assign w_op  = r_instr[27:26];
  assign w_cmd = r_instr[24:21];
  assign w_imm = r_instr[25];
  assign w_s   = r_instr[20];

  assign w_is_dp = (w_op == OP_DP)
    && (w_imm || r_instr[11:4] == 8'h00)
    && (w_cmd inside {CMD_AND, CMD_SUB, CMD_ADD,
                      CMD_CMP, CMD_ORR});
`ifdef MC_DP_MUL_EN
  assign w_is_mul = (w_op == OP_DP) && !w_imm
    && (w_cmd == 4'h0) && (r_instr[7:4] == 4'b1001);
`else
  assign w_is_mul = 1'b0;
`endif
  // Only pre-indexed, up, word, no-writeback imm12 forms.
  assign w_is_mem = (w_op == OP_MEM)
    && (r_instr[25:21] == 5'b01100);
  assign w_is_br  = (w_op == OP_BR)
    && (r_instr[25:24] == 2'b10);

  always_comb begin
    w_kind = K_NOP;
    unique case (1'b1)
      w_is_dp:  w_kind = K_DP;
      w_is_mul: w_kind = K_MUL;
      w_is_mem: w_kind = w_s ? K_LDR : K_STR;
      w_is_br:  w_kind = K_BR;
      default:  w_kind = K_NOP;
    endcase
  end

  // MUL reads Rs on port A; memory ops read Rd on port B.
  assign w_ra = w_is_mul ? r_instr[11:8] : r_instr[19:16];
  assign w_rb = w_is_mem ? r_instr[15:12] : r_instr[3:0];
  assign w_wa = w_is_mul ? r_instr[19:16] : r_instr[15:12];
  assign w_pc8 = DATA_W'(r_pc) + DATA_W'(8);

  mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk   (clk),
    .reset (reset),
    .i_ra  (w_ra),
    .i_rb  (w_rb),
    .o_rda (w_rf_a),
    .o_rdb (w_rf_b),
    .i_we  (w_rf_we),
    .i_wa  (w_wa),
    .i_wd  (w_wd),
    .i_pc8 (w_pc8)
  );

  assign w_opb = (w_is_dp && w_imm)
    ? DATA_W'(r_instr[7:0]) : w_rf_b;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res = w_sum[DATA_W-1:0];
    w_c   = r_flags[F_C];
    w_v   = r_flags[F_V];
    case (w_cmd)
      CMD_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (r_a[DATA_W-1] == r_b[DATA_W-1])
             && (w_res[DATA_W-1] != r_a[DATA_W-1]);
      end
      CMD_SUB, CMD_CMP: begin
        w_res = w_dif[DATA_W-1:0];
        w_c   = !w_dif[DATA_W];
        w_v   = (r_a[DATA_W-1] != r_b[DATA_W-1])
             && (w_res[DATA_W-1] != r_a[DATA_W-1]);
      end
      CMD_AND: w_res = r_a & r_b;
      CMD_ORR: w_res = r_a | r_b;
      default: ;
    endcase
`ifdef MC_DP_MUL_EN
    if (w_is_mul) begin
      w_res = r_a * r_b;
      w_c   = r_flags[F_C];
      w_v   = r_flags[F_V];
    end
`endif
  end

  assign w_nzcv = {w_res[DATA_W-1], w_res == '0, w_c, w_v};

  assign w_rf_we = (r_state == S_WB)
    && ((w_kind == K_LDR) || (w_kind == K_MUL)
    || (w_kind == K_DP && w_cmd != CMD_CMP));
  assign w_flag_we = (r_state == S_WB)
    && ((w_kind == K_DP && (w_s || w_cmd == CMD_CMP))
    || (w_kind == K_MUL && w_s));
  assign w_wd = (w_kind == K_LDR) ? r_ldata : w_res;

  assign w_boff = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
  assign w_btgt = r_pc + ADDR_W'(8) + ADDR_W'(w_boff);

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      S_FETCH:
        if (imem_ready) w_next = S_DECODE;
      S_DECODE:
        if (r_instr == HALT_WORD) begin
          w_next = S_HALT;
        end else if (!cond_ok(r_instr[31:28], r_flags)
                     || w_kind == K_NOP) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      S_EXEC:
        if (w_kind == K_BR) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_kind == K_LDR || w_kind == K_STR) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      S_MEM:
        if (dmem_ready) begin
          if (w_kind == K_STR) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      S_WB: begin
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ldata <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && imem_ready)
        r_instr <= imem_rdata;
      if (r_state == S_DECODE) begin
        r_a <= w_rf_a;
        r_b <= w_opb;
      end
      if (r_state == S_MEM && dmem_ready)
        r_ldata <= dmem_rdata;
      // Only a branch retires from EXEC.
      if (w_retire)
        r_pc <= (r_state == S_EXEC) ? w_btgt : r_pc + ADDR_W'(4);
      if (w_flag_we)
        r_flags <= w_nzcv;
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && (w_kind == K_STR);
  assign dmem_addr  = ADDR_W'(r_a + DATA_W'(r_instr[11:0]));
  assign dmem_wdata = r_b;
  assign pc         = r_pc;
  assign alu_flags  = r_flags;
  assign retire     = w_retire;
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: small program through imem/dmem
// models with configurable data wait states.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic [3:0]  alu_flags;
  logic        retire, halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dly = 0;
  int dcnt = 0;
  int c;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];

`ifdef MC_DP_MUL_EN
  localparam int MULC = 4;
  localparam logic [31:0] R6_EXP = 32'd40;
`else
  localparam int MULC = 2;
  localparam logic [31:0] R6_EXP = 32'd0;
`endif

  mc_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .alu_flags  (alu_flags),
    .retire     (retire),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign imem_ready = imem_req;
  assign imem_rdata = imem[imem_addr[5:2]];
  assign dmem_ready = dmem_req && (dcnt == dly);
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  always @(posedge clk) begin
    cyc <= reset ? 1 : cyc + 1;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ready)
      dmem[dmem_addr[5:2]] <= dmem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ret(output int cy);
    cy = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (retire) begin
        cy = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    imem[0] = 32'hE2801005;
    imem[1] = 32'hE2812003;
    imem[2] = 32'hE2513005;
    imem[3] = 32'h12804001;
    imem[4] = 32'hE5801010;
    imem[5] = 32'hE5905010;
    imem[6] = 32'hE0060291;
    imem[7] = 32'hEAFFFFFE;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_flags", {28'h0, alu_flags}, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h1);
    chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);

    wait_ret(c); chk("add1_cyc", c, 4);
    wait_ret(c); chk("add2_cyc", c, 8);
    chk("r1", dut.u_rf.r_regs[1], 32'd5);
    wait_ret(c); chk("subs_cyc", c, 12);
    wait_ret(c); chk("addne_cyc", c, 14);
    chk("flags_subs", {28'h0, alu_flags}, 32'h6);
    chk("r2", dut.u_rf.r_regs[2], 32'd8);
    chk("r3", dut.u_rf.r_regs[3], 32'd0);
    chk("r4_skip", dut.u_rf.r_regs[4], 32'd0);
    chk("pc_addne", pc, 32'd12);

    dly = 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req) break;
    end
    chk("str_req_cyc", cyc, 18);
    for (int k = 0; k < 3; k++) begin
      chk("str_req", {31'h0, dmem_req}, 32'h1);
      chk("str_we", {31'h0, dmem_we}, 32'h1);
      chk("str_addr", dmem_addr, 32'd16);
      chk("str_wdata", dmem_wdata, 32'd5);
      chk("str_noret", {31'h0, retire}, 32'h0);
      @(negedge clk);
    end
    chk("str_ret", {31'h0, retire}, 32'h1);
    chk("str_cyc", cyc, 21);

    wait_ret(c); chk("ldr_cyc", c, 29);
    chk("dmem4", dmem[4], 32'd5);
    wait_ret(c); chk("mul_cyc", c, 29 + MULC);
    chk("r5", dut.u_rf.r_regs[5], 32'd5);
    wait_ret(c); chk("b1_cyc", c, 32 + MULC);
    chk("r6", dut.u_rf.r_regs[6], R6_EXP);
    chk("b1_pc", pc, 32'd28);
    wait_ret(c); chk("b2_cyc", c, 35 + MULC);
    chk("b2_pc", pc, 32'd28);

    imem[7] = 32'hFFFFFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk("halt_cyc", cyc, 38 + MULC);
    repeat (3) @(negedge clk);
    chk("halt_sticky", {31'h0, halted}, 32'h1);
    chk("halt_imem", {31'h0, imem_req}, 32'h0);
    chk("halt_dmem", {31'h0, dmem_req}, 32'h0);
    chk("halt_ret", {31'h0, retire}, 32'h0);
    chk("halt_pc", pc, 32'd28);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_imem_req", {31'h0, imem_req}, 32'h1);
    chk("rst2_flags", {28'h0, alu_flags}, 32'h0);
    chk("rst2_r1", dut.u_rf.r_regs[1], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
